uart_tx_param: RTL

Parametrised UART transmitter, successor to the fixed 8N1 transmit path.
- Frame format is set at elaboration: 5-9 data bits LSB first, optional odd/even parity, 1 or 2 stop bits.
- Owns its baud timing (divider restarted per frame) and uses a valid/ready handshake instead of a level enable.
- Sits between a byte source (FIFO or control FSM) and the board TX pin.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_baud_tick.sv | 30 +++
 rtl/uart_tx_param.sv | 132 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity selectors and
// a width helper used by the transmitter and the baud divider.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam int CLKS_PER_BIT_115200 = 434;

    // Bits needed to hold 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits = bits + 1;
            rem  = rem >> 1;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// last cycle of each bit. Shared between the UART transmitter and receiver.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200
) (
    input  logic clk,
    input  logic srst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_reg;

    assign tick = en && (cnt_reg == LAST);

    always_ff @(posedge clk) begin
        if (srst || clr) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= tick ? '0 : cnt_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_BITS LSB first, optional
// parity, STOP_BITS stop bits, accepting words on a valid/ready handshake.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = PAR_NONE,
    parameter int STOP_BITS    = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [DATA_BITS-1:0] TX_Data,
    input  logic                 TX_Valid,
    output logic                 TX_Ready,
    output logic                 TX_Busy,
    output logic                 TX_Done_Sig,
    output logic                 TX_Pin_Out
);

    localparam int IDX_W = clog2(DATA_BITS + 1);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    generate
        if (PARITY_MODE < PAR_NONE || PARITY_MODE > PAR_EVEN) begin : g_bad_parity
            $error("uart_tx_param: PARITY_MODE must be 0, 1 or 2");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_tx_param: DATA_BITS must be 5..9");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_tx_param: STOP_BITS must be 1 or 2");
        end
        if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks
            $error("uart_tx_param: CLKS_PER_BIT must be 2..65535");
        end
    endgenerate

    tx_state_t             state_reg;
    logic [DATA_BITS-1:0]  shift_reg;
    logic [IDX_W-1:0]      bit_idx_reg;
    logic                  parity_reg;
    logic                  pin_reg;
    logic                  done_reg;
    logic                  handshake;
    logic                  bit_tick;

    assign TX_Ready    = (state_reg == IDLE) && !RST;
    assign TX_Busy     = (state_reg != IDLE);
    assign handshake   = TX_Valid && TX_Ready;
    assign TX_Pin_Out  = pin_reg;
    assign TX_Done_Sig = done_reg;

    // Divider restarts on every accepted word so each frame starts phase-aligned.
    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk (CLK),
        .srst(RST),
        .clr (handshake),
        .en  (TX_Busy),
        .tick(bit_tick)
    );

    // The pin register follows the state one cycle later, so the start bit
    // appears on the edge after the handshake edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            bit_idx_reg <= '0;
            parity_reg  <= 1'b0;
            pin_reg     <= 1'b1;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    pin_reg <= 1'b1;
                    if (handshake) begin
                        shift_reg   <= TX_Data;
                        parity_reg  <= (PARITY_MODE == PAR_ODD) ? ~(^TX_Data) : ^TX_Data;
                        bit_idx_reg <= '0;
                        state_reg   <= START;
                    end
                end
                START: begin
                    pin_reg <= 1'b0;
                    if (bit_tick) begin
                        state_reg <= DATA;
                    end
                end
                DATA: begin
                    pin_reg <= shift_reg[0];
                    if (bit_tick) begin
                        shift_reg <= shift_reg >> 1;
                        if (bit_idx_reg == LAST_DATA) begin
                            bit_idx_reg <= '0;
                            state_reg   <= (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + IDX_W'(1);
                        end
                    end
                end
                PARITY: begin
                    pin_reg <= parity_reg;
                    if (bit_tick) begin
                        state_reg <= STOP;
                    end
                end
                STOP: begin
                    pin_reg <= 1'b1;
                    if (bit_tick) begin
                        if (bit_idx_reg == LAST_STOP) begin
                            bit_idx_reg <= '0;
                            state_reg   <= IDLE;
                            done_reg    <= 1'b1;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    pin_reg   <= 1'b1;
                end
            endcase
        end
    end

endmodule
